// File: rtl/bg_sched_pkg.sv
// Shared types and constants for the background ROM scheduler.
package bg_sched_pkg;

  localparam int unsigned COORD_W  = 9;
  localparam int unsigned COLOUR_W = 3;

  typedef logic [COORD_W-1:0]  coord_t;
  typedef logic [COLOUR_W-1:0] colour_t;

  typedef enum logic [2:0] {
    SCAN,
    P_DOWN,
    P_RIGHT,
    P_LEFT,
    P_UP,
    P_DRAIN
  } state_t;

  typedef struct packed {
    colour_t down;
    colour_t right;
    colour_t left;
    colour_t up;
  } probe_res_t;

  localparam colour_t FREE = 3'b000;

  localparam coord_t DEF_DOWN_DX  = COORD_W'(4);
  localparam coord_t DEF_DOWN_DY  = COORD_W'(12);
  localparam coord_t DEF_RIGHT_DX = COORD_W'(11);
  localparam coord_t DEF_RIGHT_DY = COORD_W'(4);
  localparam coord_t DEF_LEFT_DX  = COORD_W'(4);
  localparam coord_t DEF_LEFT_DY  = COORD_W'(4);
  localparam coord_t DEF_UP_DX    = COORD_W'(4);
  localparam coord_t DEF_UP_DY    = COORD_W'(6);

endpackage

// File: rtl/bg_rom_scheduler_if.sv
// Signal bundle between the scheduler, the pixel/game logic and the ROM.
interface bg_rom_scheduler_if;
  import bg_sched_pkg::*;

  coord_t  max_x;
  coord_t  max_y;
  logic    frame_tick;
  coord_t  char_x;
  coord_t  char_y;
  coord_t  rom_x;
  coord_t  rom_y;
  colour_t rom_colour;
  coord_t  pix_x;
  coord_t  pix_y;
  colour_t pix_colour;
  logic    pix_valid;
  colour_t col_down;
  colour_t col_right;
  colour_t col_left;
  colour_t col_up;
  logic    probe_done;
  logic    probe_overrun;

  modport master (
    input  max_x, max_y, frame_tick, char_x, char_y, rom_colour,
    output rom_x, rom_y, pix_x, pix_y, pix_colour, pix_valid,
           col_down, col_right, col_left, col_up, probe_done, probe_overrun
  );

  modport slave (
    output max_x, max_y, frame_tick, char_x, char_y, rom_colour,
    input  rom_x, rom_y, pix_x, pix_y, pix_colour, pix_valid,
           col_down, col_right, col_left, col_up, probe_done, probe_overrun
  );

endinterface

// File: rtl/scan_counter.sv
// Raster x/y counters; wrap compares use the live limits so an out-of-range
// counter runs on until it wraps modulo 2^COORD_W.
module scan_counter
  import bg_sched_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   advance,
  input  coord_t max_x,
  input  coord_t max_y,
  output coord_t x,
  output coord_t y
);

  coord_t x_next;
  coord_t y_next;

  always_comb begin
    x_next = x;
    y_next = y;
    if (advance) begin
      if (x == max_x) begin
        x_next = '0;
        y_next = y + COORD_W'(1);
      end else begin
        x_next = x + COORD_W'(1);
      end
      if (y_next == max_y) y_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_next;
      y <= y_next;
    end
  end

endmodule

// File: rtl/bg_rom_scheduler.sv
// Shares one background ROM between the raster scan and four collision
// probes; a probe sequence steals five scan cycles per game tick.
module bg_rom_scheduler
  import bg_sched_pkg::*;
#(
  parameter coord_t DOWN_DX  = DEF_DOWN_DX,
  parameter coord_t DOWN_DY  = DEF_DOWN_DY,
  parameter coord_t RIGHT_DX = DEF_RIGHT_DX,
  parameter coord_t RIGHT_DY = DEF_RIGHT_DY,
  parameter coord_t LEFT_DX  = DEF_LEFT_DX,
  parameter coord_t LEFT_DY  = DEF_LEFT_DY,
  parameter coord_t UP_DX    = DEF_UP_DX,
  parameter coord_t UP_DY    = DEF_UP_DY
)(
  input logic                clock,
  input logic                reset,
  bg_rom_scheduler_if.master bus
);

  state_t     state, state_next;
  logic       pending, pending_next;
  logic       advance, snap_load;
  coord_t     scan_x, scan_y;
  coord_t     snap_x, snap_y;
  coord_t     rom_x, rom_y;
  probe_res_t res_q, col_q;
  coord_t     pix_x_q, pix_y_q;
  colour_t    colour_q;
  logic       pix_valid_q, probe_done_q, probe_overrun_q;

  scan_counter u_scan (
    .clock   (clock),
    .reset   (reset),
    .advance (advance),
    .max_x   (bus.max_x),
    .max_y   (bus.max_y),
    .x       (scan_x),
    .y       (scan_y)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= SCAN;
    else       state <= state_next;
  end

  // Next state, pending flag and ROM address mux.
  always_comb begin
    state_next   = state;
    pending_next = pending | bus.frame_tick;
    advance      = 1'b0;
    snap_load    = 1'b0;
    rom_x        = scan_x;
    rom_y        = scan_y;
    unique case (state)
      SCAN: begin
        advance = 1'b1;
        if (pending) begin
          state_next   = P_DOWN;
          pending_next = 1'b0;
          snap_load    = 1'b1;
        end
      end
      P_DOWN: begin
        rom_x      = snap_x + DOWN_DX;
        rom_y      = snap_y + DOWN_DY;
        state_next = P_RIGHT;
      end
      P_RIGHT: begin
        rom_x      = snap_x + RIGHT_DX;
        rom_y      = snap_y + RIGHT_DY;
        state_next = P_LEFT;
      end
      P_LEFT: begin
        rom_x      = snap_x - LEFT_DX;
        rom_y      = snap_y + LEFT_DY;
        state_next = P_UP;
      end
      P_UP: begin
        rom_x      = snap_x + UP_DX;
        rom_y      = snap_y - UP_DY;
        state_next = P_DRAIN;
      end
      P_DRAIN: state_next = SCAN;
      default: state_next = SCAN;
    endcase
  end

  // Datapath: snapshot, probe results, scan pixel pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending         <= 1'b0;
      snap_x          <= '0;
      snap_y          <= '0;
      res_q           <= '0;
      col_q           <= {FREE, FREE, FREE, FREE};
      pix_x_q         <= '0;
      pix_y_q         <= '0;
      colour_q        <= FREE;
      pix_valid_q     <= 1'b0;
      probe_done_q    <= 1'b0;
      probe_overrun_q <= 1'b0;
    end else begin
      pending         <= pending_next;
      probe_overrun_q <= bus.frame_tick & pending;
      probe_done_q    <= (state == P_DRAIN);
      pix_valid_q     <= (state == SCAN);
      if (snap_load) begin
        snap_x <= bus.char_x;
        snap_y <= bus.char_y;
      end
      if (state == SCAN) begin
        pix_x_q <= scan_x;
        pix_y_q <= scan_y;
      end
      if (pix_valid_q) colour_q <= bus.rom_colour;
      if (state == P_RIGHT) res_q.down  <= bus.rom_colour;
      if (state == P_LEFT)  res_q.right <= bus.rom_colour;
      if (state == P_UP)    res_q.left  <= bus.rom_colour;
      if (state == P_DRAIN) col_q <= {res_q.down, res_q.right, res_q.left, bus.rom_colour};
    end
  end

  assign bus.rom_x         = rom_x;
  assign bus.rom_y         = rom_y;
  assign bus.pix_x         = pix_x_q;
  assign bus.pix_y         = pix_y_q;
  // ROM data for the issued pixel lands in the pix_valid cycle; hold it after.
  assign bus.pix_colour    = pix_valid_q ? bus.rom_colour : colour_q;
  assign bus.pix_valid     = pix_valid_q;
  assign bus.col_down      = col_q.down;
  assign bus.col_right     = col_q.right;
  assign bus.col_left      = col_q.left;
  assign bus.col_up        = col_q.up;
  assign bus.probe_done    = probe_done_q;
  assign bus.probe_overrun = probe_overrun_q;

endmodule

// File: tb/tb_bg_rom_scheduler.sv
// Self-checking bench: ROM stub, raster/probe reference model, directed and random scenarios.
module tb_bg_rom_scheduler;
  import bg_sched_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  bg_rom_scheduler_if bus();

  bg_rom_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [2:0] salt = 3'b011;

  // Background picture: a few fixed tiles used by the directed probe tests, a hash elsewhere.
  function automatic colour_t rom_fn(coord_t x, coord_t y);
    if (x == 9'd39 && y == 9'd217) return 3'b010;
    if (x == 9'd46 && y == 9'd209) return 3'b000;
    if (x == 9'd31 && y == 9'd209) return 3'b000;
    if (x == 9'd39 && y == 9'd199) return 3'b101;
    return colour_t'(x[2:0] ^ y[3:1] ^ salt ^ {x[4], y[0], x[3]});
  endfunction

  function automatic probe_res_t exp_cols(coord_t cx, coord_t cy);
    probe_res_t r;
    r.down  = rom_fn(COORD_W'(cx + 4),  COORD_W'(cy + 12));
    r.right = rom_fn(COORD_W'(cx + 11), COORD_W'(cy + 4));
    r.left  = rom_fn(COORD_W'(cx - 4),  COORD_W'(cy + 4));
    r.up    = rom_fn(COORD_W'(cx + 4),  COORD_W'(cy - 6));
    return r;
  endfunction

  function automatic void raster_next(inout coord_t x, inout coord_t y, input coord_t lx, input coord_t ly);
    if (x == lx) begin
      x = '0;
      y = COORD_W'(y + 1);
    end else begin
      x = COORD_W'(x + 1);
    end
    if (y == ly) y = '0;
  endfunction

  always @(posedge clock) bus.rom_colour <= rom_fn(bus.rom_x, bus.rom_y);

  // Pixel-stream model: every valid pixel must be the next raster position with its ROM colour.
  bit     mon_en = 1'b0;
  bit     rnd_cols = 1'b0;
  coord_t mx, my;
  coord_t rcx, rcy;
  int     valid_cnt, gap_cnt, done_cnt, ovr_cnt;

  always @(negedge clock) begin
    if (mon_en) begin
      if (bus.pix_valid) begin
        checks++;
        if (bus.pix_x !== mx || bus.pix_y !== my || bus.pix_colour !== rom_fn(mx, my)) begin
          failures++;
          $display("FAIL pixel got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                   bus.pix_x, bus.pix_y, bus.pix_colour, mx, my, rom_fn(mx, my));
        end
        raster_next(mx, my, bus.max_x, bus.max_y);
        valid_cnt++;
      end else begin
        gap_cnt++;
      end
      if (bus.probe_done) done_cnt++;
      if (bus.probe_overrun) ovr_cnt++;
      if (rnd_cols && bus.probe_done) begin
        checks++;
        if ({bus.col_down, bus.col_right, bus.col_left, bus.col_up} !== exp_cols(rcx, rcy)) begin
          failures++;
          $display("FAIL rnd_cols got=%h exp=%h",
                   {bus.col_down, bus.col_right, bus.col_left, bus.col_up}, exp_cols(rcx, rcy));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input coord_t lx, input coord_t ly);
    mon_en = 1'b0;
    bus.frame_tick = 1'b0;
    bus.max_x = lx;
    bus.max_y = ly;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    mx = '0;
    my = '0;
    valid_cnt = 0; gap_cnt = 0; done_cnt = 0; ovr_cnt = 0;
    step();
    mon_en = 1'b1;
  endtask

  task automatic fire_tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    bus.frame_tick = 1'b0;
    bus.max_x = 9'd3;
    bus.max_y = 9'd2;
    bus.char_x = '0;
    bus.char_y = '0;
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({bus.pix_valid, bus.probe_done, bus.probe_overrun} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {bus.pix_valid, bus.probe_done, bus.probe_overrun});
    end
    checks++;
    if ({bus.col_down, bus.col_right, bus.col_left, bus.col_up} !== 12'h000) begin
      failures++;
      $display("FAIL reset_cols got=%h exp=000", {bus.col_down, bus.col_right, bus.col_left, bus.col_up});
    end
    checks++;
    if (bus.pix_x !== 9'd0 || bus.pix_y !== 9'd0 || bus.pix_colour !== 3'd0) begin
      failures++;
      $display("FAIL reset_pix got=(%0d,%0d,%0d) exp=(0,0,0)", bus.pix_x, bus.pix_y, bus.pix_colour);
    end
    checks++;
    if (bus.rom_x !== 9'd0 || bus.rom_y !== 9'd0) begin
      failures++;
      $display("FAIL reset_rom got=(%0d,%0d) exp=(0,0)", bus.rom_x, bus.rom_y);
    end
    reset = 1'b0;
    mx = '0;
    my = '0;
    valid_cnt = 0; gap_cnt = 0; done_cnt = 0; ovr_cnt = 0;
    step();
    mon_en = 1'b1;
  endtask

  task automatic test_scan();
    coord_t ix = 9'd1;
    coord_t iy = 9'd0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.pix_valid !== 1'b1 || bus.rom_x !== ix || bus.rom_y !== iy) begin
        failures++;
        $display("FAIL scan_issue got=(%b,%0d,%0d) exp=(1,%0d,%0d)", bus.pix_valid, bus.rom_x, bus.rom_y, ix, iy);
      end
      raster_next(ix, iy, 9'd3, 9'd2);
      step();
    end
  endtask

  task automatic test_probe();
    coord_t ax[4] = '{9'd39, 9'd46, 9'd31, 9'd39};
    coord_t ay[4] = '{9'd217, 9'd209, 9'd209, 9'd199};
    do_reset(9'd15, 9'd7);
    bus.char_x = 9'd35;
    bus.char_y = 9'd205;
    step(); step(); step();
    fire_tick();
    step();
    for (int n = 2; n <= 5; n++) begin
      checks++;
      if (bus.rom_x !== ax[n-2] || bus.rom_y !== ay[n-2] || bus.probe_done !== 1'b0) begin
        failures++;
        $display("FAIL probe_addr%0d got=(%0d,%0d,%b) exp=(%0d,%0d,0)", n, bus.rom_x, bus.rom_y, bus.probe_done, ax[n-2], ay[n-2]);
      end
      step();
    end
    checks++;
    if (bus.probe_done !== 1'b0 || bus.pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL probe_drain got=(%b,%b) exp=(0,0)", bus.probe_done, bus.pix_valid);
    end
    step();
    checks++;
    if (bus.probe_done !== 1'b1 || {bus.col_down, bus.col_right, bus.col_left, bus.col_up} !== {3'b010, 3'b000, 3'b000, 3'b101}) begin
      failures++;
      $display("FAIL probe_result got=(%b,%h) exp=(1,%h)", bus.probe_done,
               {bus.col_down, bus.col_right, bus.col_left, bus.col_up}, {3'b010, 3'b000, 3'b000, 3'b101});
    end
    step();
    checks++;
    if (bus.probe_done !== 1'b0 || bus.pix_valid !== 1'b1) begin
      failures++;
      $display("FAIL probe_after got=(%b,%b) exp=(0,1)", bus.probe_done, bus.pix_valid);
    end
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (gap_cnt !== 5 || done_cnt !== 1) begin
      failures++;
      $display("FAIL probe_cost got=(gaps %0d,dones %0d) exp=(5,1)", gap_cnt, done_cnt);
    end
  endtask

  task automatic test_wrap();
    coord_t ax[4] = '{9'd6, 9'd13, 9'd510, 9'd6};
    coord_t ay[4] = '{9'd15, 9'd7, 9'd7, 9'd509};
    bus.char_x = 9'd2;
    bus.char_y = 9'd3;
    fire_tick();
    step();
    for (int n = 2; n <= 5; n++) begin
      checks++;
      if (bus.rom_x !== ax[n-2] || bus.rom_y !== ay[n-2]) begin
        failures++;
        $display("FAIL wrap_addr%0d got=(%0d,%0d) exp=(%0d,%0d)", n, bus.rom_x, bus.rom_y, ax[n-2], ay[n-2]);
      end
      step();
    end
    step();
    checks++;
    if (bus.probe_done !== 1'b1 || {bus.col_down, bus.col_right, bus.col_left, bus.col_up} !== exp_cols(9'd2, 9'd3)) begin
      failures++;
      $display("FAIL wrap_result got=(%b,%h) exp=(1,%h)", bus.probe_done,
               {bus.col_down, bus.col_right, bus.col_left, bus.col_up}, exp_cols(9'd2, 9'd3));
    end
    step();
  endtask

  task automatic test_overrun();
    int ovr = 0;
    int dones = 0;
    do_reset(9'd15, 9'd7);
    bus.char_x = 9'd100;
    bus.char_y = 9'd50;
    step(); step();
    bus.frame_tick = 1'b1;
    step();
    ovr += int'(bus.probe_overrun);
    step();
    bus.frame_tick = 1'b0;
    checks++;
    if (bus.probe_overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pulse got=%b exp=1", bus.probe_overrun);
    end
    ovr += int'(bus.probe_overrun);
    for (int n = 3; n <= 14; n++) begin
      step();
      ovr += int'(bus.probe_overrun);
      dones += int'(bus.probe_done);
      if (n == 4) begin
        checks++;
        if (bus.rom_x !== 9'd96 || bus.rom_y !== 9'd54) begin
          failures++;
          $display("FAIL overrun_left got=(%0d,%0d) exp=(96,54)", bus.rom_x, bus.rom_y);
        end
        bus.frame_tick = 1'b1;
      end
      if (n == 5) bus.frame_tick = 1'b0;
      if (n == 7) begin
        checks++;
        if (bus.probe_done !== 1'b1 || bus.pix_valid !== 1'b0 || bus.rom_x !== mx || bus.rom_y !== my) begin
          failures++;
          $display("FAIL resume_scan got=(%b,%b,%0d,%0d) exp=(1,0,%0d,%0d)", bus.probe_done, bus.pix_valid, bus.rom_x, bus.rom_y, mx, my);
        end
      end
      if (n == 8) begin
        checks++;
        if (bus.pix_valid !== 1'b1 || bus.rom_x !== 9'd104 || bus.rom_y !== 9'd62) begin
          failures++;
          $display("FAIL restart_probe got=(%b,%0d,%0d) exp=(1,104,62)", bus.pix_valid, bus.rom_x, bus.rom_y);
        end
      end
    end
    checks++;
    if (ovr !== 1 || dones !== 2) begin
      failures++;
      $display("FAIL overrun_count got=(ovr %0d,done %0d) exp=(1,2)", ovr, dones);
    end
  endtask

  task automatic test_snapshot();
    bus.char_x = 9'd35;
    bus.char_y = 9'd205;
    step();
    fire_tick();
    step();
    step();
    bus.char_x = 9'd80;
    step();
    checks++;
    if (bus.rom_x !== 9'd31 || bus.rom_y !== 9'd209) begin
      failures++;
      $display("FAIL snap_left got=(%0d,%0d) exp=(31,209)", bus.rom_x, bus.rom_y);
    end
    step();
    checks++;
    if (bus.rom_x !== 9'd39 || bus.rom_y !== 9'd199) begin
      failures++;
      $display("FAIL snap_up got=(%0d,%0d) exp=(39,199)", bus.rom_x, bus.rom_y);
    end
    step();
    step();
    checks++;
    if ({bus.col_down, bus.col_right, bus.col_left, bus.col_up} !== {3'b010, 3'b000, 3'b000, 3'b101}) begin
      failures++;
      $display("FAIL snap_result got=%h exp=%h", {bus.col_down, bus.col_right, bus.col_left, bus.col_up}, {3'b010, 3'b000, 3'b000, 3'b101});
    end
    bus.char_x = 9'd35;
    step();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    do_reset(9'd15, 9'd7);
    bus.char_x = 9'd35;
    bus.char_y = 9'd205;
    step();
    fire_tick();
    for (int n = 2; n <= 5; n++) step();
    checks++;
    if (bus.rom_x !== 9'd39 || bus.rom_y !== 9'd199) begin
      failures++;
      $display("FAIL mid_up got=(%0d,%0d) exp=(39,199)", bus.rom_x, bus.rom_y);
    end
    mon_en = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if (bus.rom_x !== 9'd0 || bus.rom_y !== 9'd0 || bus.probe_done !== 1'b0 ||
        {bus.col_down, bus.col_right, bus.col_left, bus.col_up} !== 12'h000) begin
      failures++;
      $display("FAIL mid_reset got=(%0d,%0d,%b,%h) exp=(0,0,0,000)", bus.rom_x, bus.rom_y, bus.probe_done,
               {bus.col_down, bus.col_right, bus.col_left, bus.col_up});
    end
    reset = 1'b0;
    mx = '0;
    my = '0;
    step();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dones += int'(bus.probe_done);
      step();
    end
    checks++;
    if (dones !== 0 || {bus.col_down, bus.col_right, bus.col_left, bus.col_up} !== 12'h000) begin
      failures++;
      $display("FAIL mid_no_done got=(%0d,%h) exp=(0,000)", dones, {bus.col_down, bus.col_right, bus.col_left, bus.col_up});
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 3; run++) begin
      int ticks = 0;
      salt = 3'($urandom);
      rcx = 9'($urandom);
      rcy = 9'($urandom);
      bus.char_x = rcx;
      bus.char_y = rcy;
      do_reset(9'($urandom_range(2, 20)), 9'($urandom_range(1, 10)));
      rnd_cols = 1'b1;
      for (int c = 0; c < 300; c++) begin
        bus.frame_tick = (c == 0) || ($urandom_range(0, 9) == 0);
        ticks += int'(bus.frame_tick);
        step();
      end
      bus.frame_tick = 1'b0;
      for (int c = 0; c < 16; c++) step();
      rnd_cols = 1'b0;
      checks++;
      if (done_cnt + ovr_cnt !== ticks || done_cnt < 1) begin
        failures++;
        $display("FAIL rnd_ticks run%0d got=(done %0d + ovr %0d) exp=%0d", run, done_cnt, ovr_cnt, ticks);
      end
      checks++;
      if (gap_cnt !== 5 * done_cnt) begin
        failures++;
        $display("FAIL rnd_gaps run%0d got=%0d exp=%0d", run, gap_cnt, 5 * done_cnt);
      end
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.max_x = 9'd3;
    bus.max_y = 9'd2;
    bus.char_x = '0;
    bus.char_y = '0;
    test_reset();
    test_scan();
    test_probe();
    test_wrap();
    test_overrun();
    test_snapshot();
    test_reset_mid();
    test_random();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
